// File: rtl/cpu_reg_file_pkg.sv
// Shared constants and types for the multi-port CPU integer register file.
// Decode and writeback import the same defaults so their buses stay the same width.
package cpu_reg_file_pkg;

   localparam int NUM_REGS_DEF   = 32;
   localparam int DATA_WIDTH_DEF = 32;

   // NUM_REGS is a power of two and at least 2, so $clog2 never returns 0
   function automatic int addr_w(input int num_regs);
      return (num_regs < 2) ? 1 : $clog2(num_regs);
   endfunction

   localparam int ADDR_W_DEF = addr_w(NUM_REGS_DEF);

   typedef logic [ADDR_W_DEF-1:0]     reg_addr_t;
   typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/cpu_reg_file_mp_if.sv
// Decode/issue and writeback bus into the register file.
// master = pipeline side (decode + writeback), slave = register file.
interface cpu_reg_file_mp_if
   import cpu_reg_file_pkg::*;
#(
   parameter int NUM_REGS   = NUM_REGS_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2
);
   localparam int ADDR_W = addr_w(NUM_REGS);

   // No handshake: reads are combinational, and writes, issues and flushes
   // are single-cycle strobes sampled at the rising clock edge.
   logic [NUM_READ-1:0][ADDR_W-1:0]      rd_addr;
   logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data;
   logic [NUM_READ-1:0]                  rd_busy;
   logic [NUM_WRITE-1:0]                 wr_en;
   logic [NUM_WRITE-1:0][ADDR_W-1:0]     wr_addr;
   logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wr_data;
   logic                                 issue_en;
   logic [ADDR_W-1:0]                    issue_addr;
   logic                                 flush;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/cpu_reg_scoreboard.sv
// Per-register pending (busy) bits: issue sets, writeback clears, flush clears all.
// Priority at each edge is flush > issue > writeback > hold.
module cpu_reg_scoreboard
   import cpu_reg_file_pkg::*;
#(
   parameter int NUM_REGS  = NUM_REGS_DEF,
   parameter int NUM_WRITE = 2,
   parameter int ZERO_REG  = 1,
   localparam int ADDR_W   = addr_w(NUM_REGS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             issue_en,
   input  logic [ADDR_W-1:0]                issue_addr,
   input  logic                             flush,
   input  logic [NUM_WRITE-1:0]             wr_en,
   input  logic [NUM_WRITE-1:0][ADDR_W-1:0] wr_addr,
   output logic [NUM_REGS-1:0]              busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;

   always_comb begin
      set_vec             = '0;
      set_vec[issue_addr] = issue_en;
      clr_vec             = '0;
      for (int i = 0; i < NUM_WRITE; i++) begin
         if (wr_en[i]) clr_vec[wr_addr[i]] = 1'b1;
      end
   end

   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (flush)           busy_d[r] = 1'b0;
         else if (set_vec[r]) busy_d[r] = 1'b1;
         else if (clr_vec[r]) busy_d[r] = 1'b0;
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/cpu_reg_file_mp.sv
// Multi-port CPU integer register file with a pending-register scoreboard.
// Optional write-to-read bypass: define CPU_REG_FILE_BYPASS_EN.
module cpu_reg_file_mp
   import cpu_reg_file_pkg::*;
#(
   parameter int NUM_REGS   = NUM_REGS_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic               clock,
   input  logic               reset,
   cpu_reg_file_mp_if.slave   bus
);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_d;
   logic [NUM_REGS-1:0]                 busy;

   // Later ports overwrite earlier ones, so the highest enabled index wins
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < NUM_WRITE; i++) begin
         if (bus.wr_en[i]) mem_d[bus.wr_addr[i]] = bus.wr_data[i];
      end
      if (ZERO_REG != 0) mem_d[0] = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   cpu_reg_scoreboard #(
      .NUM_REGS  (NUM_REGS),
      .NUM_WRITE (NUM_WRITE),
      .ZERO_REG  (ZERO_REG)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .issue_en   (bus.issue_en),
      .issue_addr (bus.issue_addr),
      .flush      (bus.flush),
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .busy       (busy)
   );

   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int j = 0; j < NUM_READ; j++) begin
         bus.rd_data[j] = mem_q[bus.rd_addr[j]];
         bus.rd_busy[j] = busy[bus.rd_addr[j]];
`ifdef CPU_REG_FILE_BYPASS_EN
         // A forwarded value is already produced, so it is only pending if
         // a newer producer issues to the same register this cycle.
         for (int i = 0; i < NUM_WRITE; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i] == bus.rd_addr[j])) begin
               bus.rd_data[j] = bus.wr_data[i];
               bus.rd_busy[j] = bus.issue_en && (bus.issue_addr == bus.rd_addr[j]);
            end
         end
`endif
         if ((ZERO_REG != 0) && (bus.rd_addr[j] == '0)) begin
            bus.rd_data[j] = '0;
            bus.rd_busy[j] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_reg_file_mp.sv
// Directed bench for cpu_reg_file_mp: data path, write conflicts, scoreboard,
// register 0 masking, flush priority, bypass timing and asynchronous reset.
module tb_cpu_reg_file_mp;

   localparam int NUM_REGS   = 32;
   localparam int DATA_WIDTH = 32;
   localparam int NUM_READ   = 2;
   localparam int NUM_WRITE  = 2;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   cpu_reg_file_mp_if #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_READ   (NUM_READ),
      .NUM_WRITE  (NUM_WRITE)
   ) bus ();

   cpu_reg_file_mp #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_READ   (NUM_READ),
      .NUM_WRITE  (NUM_WRITE),
      .ZERO_REG   (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Returns 1 time unit after a rising edge; inputs set here are sampled at the next edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en      = '0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.issue_en   = 1'b0;
      bus.issue_addr = '0;
      bus.flush      = 1'b0;
   endtask

   task automatic wr(input int port, input int addr, input logic [31:0] data);
      bus.wr_en[port]   = 1'b1;
      bus.wr_addr[port] = 5'(addr);
      bus.wr_data[port] = data;
   endtask

   task automatic iss(input int addr);
      bus.issue_en   = 1'b1;
      bus.issue_addr = 5'(addr);
   endtask

   task automatic rd(input int a0, input int a1);
      bus.rd_addr[0] = 5'(a0);
      bus.rd_addr[1] = 5'(a1);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      idle_inputs();
      bus.rd_addr = '0;
      step();
      step();
      rd(3, 31);
      check("reset_data0", bus.rd_data[0], 32'h0);
      check("reset_data1", bus.rd_data[1], 32'h0);
      check("reset_busy",  {30'b0, bus.rd_busy}, 32'h0);
      reset = 1'b1;
      step();

      // Basic write then read
      wr(0, 2, 32'h2);
      step();
      idle_inputs();
      rd(2, 1);
      check("r2_data", bus.rd_data[0], 32'h2);
      check("r1_data", bus.rd_data[1], 32'h0);
      check("r2_r1_busy", {30'b0, bus.rd_busy}, 32'h0);

      // Same-cycle conflict: port 1 wins
      wr(0, 5, 32'hAA);
      wr(1, 5, 32'hBB);
      step();
      idle_inputs();
      rd(5, 2);
      check("conflict_r5", bus.rd_data[0], 32'hBB);

      // Issue r7, busy persists until writeback
      iss(7);
      step();
      idle_inputs();
      step();
      step();
      step();
      rd(7, 5);
      check("r7_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
      check("r5_not_busy", {31'b0, bus.rd_busy[1]}, 32'h0);
      wr(1, 7, 32'h14);
      step();
      idle_inputs();
      rd(7, 5);
      check("r7_clr_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
      check("r7_data", bus.rd_data[0], 32'h14);
      iss(7);
      wr(0, 7, 32'h20);
      step();
      idle_inputs();
      rd(7, 5);
      check("r7_issue_beats_wb", {31'b0, bus.rd_busy[0]}, 32'h1);
      check("r7_data2", bus.rd_data[0], 32'h20);

      // Writeback to a register that was never issued
      wr(0, 10, 32'hCAFE);
      step();
      idle_inputs();
      rd(10, 7);
      check("r10_data", bus.rd_data[0], 32'hCAFE);
      check("r10_busy", {31'b0, bus.rd_busy[0]}, 32'h0);

      // Register 0 ignores writes and issues
      wr(0, 0, 32'hFFFF_FFFF);
      iss(0);
      step();
      idle_inputs();
      rd(0, 0);
      check("r0_data", bus.rd_data[0], 32'h0);
      check("r0_busy", {31'b0, bus.rd_busy[0]}, 32'h0);

      // Flush clears all bits and overrides a same-cycle issue
      iss(3);
      step();
      iss(4);
      step();
      idle_inputs();
      rd(3, 4);
      check("r3_r4_busy", {30'b0, bus.rd_busy}, 32'h3);
      bus.flush = 1'b1;
      iss(9);
      step();
      idle_inputs();
      rd(3, 4);
      check("flush_r3_r4", {30'b0, bus.rd_busy}, 32'h0);
      rd(9, 7);
      check("flush_r9_r7", {30'b0, bus.rd_busy}, 32'h0);

      // Bypass timing on r6
      wr(0, 6, 32'h11);
      step();
      idle_inputs();
      wr(0, 6, 32'h55);
      rd(6, 2);
`ifdef CPU_REG_FILE_BYPASS_EN
      check("r6_before_edge", bus.rd_data[0], 32'h55);
`else
      check("r6_before_edge", bus.rd_data[0], 32'h11);
`endif
      check("r2_unaffected", bus.rd_data[1], 32'h2);
      step();
      idle_inputs();
      rd(6, 2);
      check("r6_after_edge", bus.rd_data[0], 32'h55);

      // Asynchronous reset mid-write
      iss(11);
      step();
      idle_inputs();
      rd(5, 11);
      check("r11_busy_pre", {31'b0, bus.rd_busy[1]}, 32'h1);
      wr(0, 8, 32'h77);
      #1;
      reset = 1'b0;
      #1;
      check("rst_r5_data", bus.rd_data[0], 32'h0);
      check("rst_r11_busy", {31'b0, bus.rd_busy[1]}, 32'h0);
      step();
      rd(8, 6);
      check("rst_held_r8", bus.rd_data[0], 32'h0);
      check("rst_held_r6", bus.rd_data[1], 32'h0);
      idle_inputs();
      reset = 1'b1;
      step();
      rd(8, 5);
      check("post_rst_r8", bus.rd_data[0], 32'h0);
      check("post_rst_r5", bus.rd_data[1], 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
